// File: rtl/frame_grabber.sv
// Frame grabber: after an arm request, skips SKIP_FRAMES whole frames, then
// captures one WIDTH*HEIGHT frame of RGB565 pixel pairs, converts each pixel
// to RGB332 and writes it to sequential frame buffer addresses.
module frame_grabber #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic [31:0]       rgb,
  input  logic              rgb_valid,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              busy,
  output logic              done,
  output logic              short_frame,
  output logic              overrun,
  output logic [ADDR_W-1:0] pixel_count
);

  localparam int unsigned TOTAL = WIDTH * HEIGHT;
  localparam int unsigned SKW   = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [SKW-1:0]    SKIP_INIT = SKW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [SKW-1:0]    skip_cnt, skip_n;
  logic [ADDR_W-1:0] cnt_n;
  logic              pend, pend_n;
  logic [7:0]        pend_px, pend_px_n;
  logic              end_req, end_req_n;
  logic              full_q, full_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        data_n;
  logic              short_n, over_n;

  logic [7:0]        px0_332, px1_332;
  logic              unused_rgb_bits;

  // RGB565 -> RGB332 keeps the top bits of each colour channel
  assign px0_332 = {rgb[15:13], rgb[10:8], rgb[4:3]};
  assign px1_332 = {rgb[31:29], rgb[26:24], rgb[20:19]};
  assign unused_rgb_bits = ^{rgb[28:27], rgb[23:21], rgb[18:16],
                             rgb[12:11], rgb[7:5], rgb[2:0]};

  // Status flags decode directly from the state register
  assign busy = (state == S_WAIT_SOF) || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and datapath next-value logic.
  // Writes are issued one cycle ahead of their visible buf_we, so leaving
  // CAPTURE (full or early end) is only decided in a cycle that issues no
  // write; this keeps buf_we from ever showing up in DONE.
  always_comb begin
    state_n   = state;
    skip_n    = skip_cnt;
    cnt_n     = pixel_count;
    pend_n    = pend;
    pend_px_n = pend_px;
    end_req_n = end_req;
    full_n    = full_q;
    we_n      = 1'b0;
    addr_n    = buf_addr;
    data_n    = buf_data;
    short_n   = short_frame;
    over_n    = overrun;

    case (state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_n   = S_WAIT_SOF;
          skip_n    = SKIP_INIT;
          short_n   = 1'b0;
          over_n    = 1'b0;
          cnt_n     = '0;
          full_n    = 1'b0;
          end_req_n = 1'b0;
          pend_n    = 1'b0;
        end
      end

      S_WAIT_SOF: begin
        if (frame_start) begin
          if (skip_cnt == '0) begin
            state_n   = S_CAPTURE;
            cnt_n     = '0;
            full_n    = 1'b0;
            end_req_n = 1'b0;
            pend_n    = 1'b0;
          end else begin
            skip_n = skip_cnt - 1'b1;
          end
        end
      end

      S_CAPTURE: begin
        if (full_q) begin
          // frame complete: any pending pixel1 is dropped
          state_n = S_DONE;
          pend_n  = 1'b0;
        end else if (pend) begin
          we_n      = 1'b1;
          addr_n    = pixel_count;
          data_n    = pend_px;
          cnt_n     = pixel_count + 1'b1;
          full_n    = (pixel_count == LAST_ADDR);
          pend_n    = 1'b0;
          end_req_n = end_req | frame_end;
          if (rgb_valid) over_n = 1'b1;
        end else if (end_req || frame_end) begin
          state_n   = S_DONE;
          short_n   = 1'b1;
          end_req_n = 1'b0;
        end else if (rgb_valid) begin
          we_n      = 1'b1;
          addr_n    = pixel_count;
          data_n    = px0_332;
          cnt_n     = pixel_count + 1'b1;
          full_n    = (pixel_count == LAST_ADDR);
          pend_n    = 1'b1;
          pend_px_n = px1_332;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_cnt    <= '0;
      pixel_count <= '0;
      pend        <= 1'b0;
      pend_px     <= '0;
      end_req     <= 1'b0;
      full_q      <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      short_frame <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      skip_cnt    <= skip_n;
      pixel_count <= cnt_n;
      pend        <= pend_n;
      pend_px     <= pend_px_n;
      end_req     <= end_req_n;
      full_q      <= full_n;
      buf_we      <= we_n;
      buf_addr    <= addr_n;
      buf_data    <= data_n;
      short_frame <= short_n;
      overrun     <= over_n;
    end
  end

endmodule

// File: doc/frame_grabber.md
Name: frame_grabber

Overview:
- Sits between the RGB565 unpacker and the frame buffer write port, in the camera pixel clock domain.
- On an arm request it skips a programmable number of whole frames, then captures exactly one frame of WIDTH*HEIGHT pixels.
- Each pixel is converted to RGB332 and written to sequential buffer addresses.
- It then reports done, so the UART readout can start without racing the writer.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- ADDR_W, 20, buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- SKIP_FRAMES, 2, complete frames ignored after arm before capture (sensor settling); 0 allowed.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- arm  in  1  one-cycle request to capture a frame; ignored unless state is IDLE or DONE.
- frame_start  in  1  one-cycle pulse, frame start short packet.
- frame_end  in  1  one-cycle pulse, frame end short packet.
- rgb  in  32  two RGB565 pixels: pixel0 = rgb[15:0], pixel1 = rgb[31:16].
- rgb_valid  in  1  one-cycle strobe, rgb holds a new pixel pair.
- buf_we  out  1  buffer write enable.
- buf_addr  out  ADDR_W  buffer write address.
- buf_data  out  8  RGB332 pixel.
- busy  out  1  high in WAIT_SOF and CAPTURE.
- done  out  1  high in DONE.
- short_frame  out  1  sticky: last capture ended early at frame_end.
- overrun  out  1  sticky: rgb_valid arrived while pixel1 was still pending.
- pixel_count  out  ADDR_W  pixels written in the current/last capture.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; skip counter, address and pending register cleared.
- Conversion, combinational per pixel p: buf_data = {p[15:13], p[10:8], p[4:3]}.
- States:
  - IDLE: wait for arm; on arm -> WAIT_SOF, skip_cnt=SKIP_FRAMES, clear short_frame, overrun and pixel_count.
  - WAIT_SOF: on frame_start, if skip_cnt==0 -> CAPTURE with addr=0; otherwise skip_cnt decrements on each frame_start. rgb_valid is ignored.
  - CAPTURE: per rgb_valid, write pixel0 in the cycle after the strobe and pixel1 in the following cycle. buf_addr increments after each write; pixel_count tracks writes.
  - CAPTURE exit, full: when pixel_count reaches WIDTH*HEIGHT -> DONE. The remaining pixel of a pair is discarded if the frame is full. No further writes.
  - CAPTURE exit, early: frame_end arriving before full -> DONE with short_frame=1. A pending pixel1 is still written first.
  - DONE: hold outputs; arm -> WAIT_SOF exactly as from IDLE.
- Latency: strobe at cycle N gives buf_we at N+1 (pixel0) and N+2 (pixel1). buf_we is never asserted outside CAPTURE.
- Back-to-back rgb_valid: a strobe at N+1 (pixel1 still pending) sets overrun=1 and is dropped; the pending pixel1 write completes. Upstream's normal rate is at most one strobe per 2 cycles.
- Simultaneous frame_start and arm in IDLE: arm is taken; that frame_start is not counted.
- frame_start during CAPTURE: ignored (no restart); capture continues and a misaligned frame is flagged only via short_frame/pixel_count.
- arm during WAIT_SOF/CAPTURE: ignored.
- Address never wraps: writes stop at WIDTH*HEIGHT-1.
- Reset mid-capture: immediate return to IDLE, buf_we deasserts asynchronously.

Test Plan:
- WIDTH=4, HEIGHT=2, SKIP_FRAMES=0. Arm, frame_start, then 4 strobes spaced 3 cycles, rgb=32'hF800_07E0 -> writes addr 0..7, buf_data alternating 8'h1C, 8'hE0. done=1, pixel_count=8, short_frame=0.
- SKIP_FRAMES=2. Arm, then three frames of data -> no buf_we during frames 1 and 2; frame 3 captured at addr 0..7.
- Capture started, frame_end after 2 strobes -> 4 writes, done=1, short_frame=1, pixel_count=4.
- Strobes in consecutive cycles -> overrun=1; the second pair is not written; addresses stay contiguous.
- Five strobes in one frame (10 pixels, frame holds 8) -> exactly 8 writes, last at addr 7, then DONE; excess data is not written.
- Assert reset in the middle of CAPTURE -> buf_we=0 and state IDLE in the same cycle. Re-arm -> capture restarts at addr 0.
